// File: rtl/series_pkg.sv
// Shared types and constants for the 8.8 fixed-point series-evaluation controller.
// The controller imports this package, and so can other blocks in the series datapath.
package series_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SQR,
    MUL_X,
    MUL_C,
    CHECK,
    ACC,
    DONE
  } state_t;

  localparam logic [15:0] FP_ONE    = 16'h0100;
  localparam int          FP_FRAC   = 8;
  localparam int          MAX_TERMS = 8;
  localparam int          ROM_DEPTH = 8;

endpackage

// File: rtl/series_ctrl_if.sv
// Controller bundle: start/done handshake with the top level plus every
// datapath select/strobe line and the comparator feedback.
interface series_ctrl_if;

  logic       start;
  logic       less_cmp;
  logic       busy;
  logic       done;
  logic [3:0] terms_used;
  logic       s1_rom;
  logic       s1_x;
  logic       s2_tmp;
  logic       s2_x;
  logic       s4_in;
  logic       s4_mult;
  logic [7:0] s3;
  logic       ld_tmp;
  logic       init_tmp;
  logic       ld_ans;
  logic       init_ans;
  logic       ld_x;
  logic       ld_y;
  logic       sub;

  modport master (
    input  start, less_cmp,
    output busy, done, terms_used,
    output s1_rom, s1_x, s2_tmp, s2_x, s4_in, s4_mult, s3,
    output ld_tmp, init_tmp, ld_ans, init_ans, ld_x, ld_y, sub
  );

  modport slave (
    output start, less_cmp,
    input  busy, done, terms_used,
    input  s1_rom, s1_x, s2_tmp, s2_x, s4_in, s4_mult, s3,
    input  ld_tmp, init_tmp, ld_ans, init_ans, ld_x, ld_y, sub
  );

endinterface

// File: rtl/series_ctrl.sv
// Moore control FSM sequencing one series evaluation through the datapath:
// optional x*x, then per term tmp*=x, tmp*=rom[k], threshold check, accumulate.
module series_ctrl
  import series_pkg::*;
#(
  parameter int N_TERMS  = 8,
  parameter bit SQUARE_X = 1'b0,
  parameter bit ALT_SIGN = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  series_ctrl_if.master bus
);

  localparam logic [2:0] K_LAST = 3'(N_TERMS - 1);

  state_t     state;
  state_t     state_nx;
  logic [2:0] k;
  logic [3:0] terms_used;

  logic       s1_rom;
  logic       s2_x;
  logic       s4_in;
  logic [7:0] s3;
  logic       ld_tmp;
  logic       init_tmp;
  logic       ld_ans;
  logic       init_ans;
  logic       ld_x;
  logic       ld_y;
  logic       sub;
  logic       busy;
  logic       done;

  // NOTE: state-holding registers use non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      terms_used <= '0;
    end else begin
      state <= state_nx;
      case (state)
        INIT: begin
          k          <= '0;
          terms_used <= '0;
        end
        ACC: begin
          terms_used <= terms_used + 4'd1;
          // The terminal test precedes the increment, so k never wraps.
          if (k != K_LAST) k <= k + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every signal gets a default before the case so no path through
  // this block leaves one unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    s1_rom   = 1'b0;
    s2_x     = 1'b0;
    s4_in    = 1'b0;
    s3       = '0;
    ld_tmp   = 1'b0;
    init_tmp = 1'b0;
    ld_ans   = 1'b0;
    init_ans = 1'b0;
    ld_x     = 1'b0;
    ld_y     = 1'b0;
    sub      = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;

    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) state_nx = INIT;
      end
      INIT: begin
        init_tmp = 1'b1;
        init_ans = 1'b1;
        ld_x     = 1'b1;
        s4_in    = 1'b1;
        ld_y     = 1'b1;
        state_nx = SQUARE_X ? SQR : MUL_X;
      end
      SQR: begin
        s2_x     = 1'b1;
        ld_x     = 1'b1;
        state_nx = MUL_X;
      end
      MUL_X: begin
        ld_tmp   = 1'b1;
        state_nx = MUL_C;
      end
      MUL_C: begin
        s1_rom   = 1'b1;
        s3       = {5'b0, k};
        ld_tmp   = 1'b1;
        state_nx = CHECK;
      end
      CHECK: begin
        // A term already below threshold ends the run without being added.
        state_nx = bus.less_cmp ? DONE : ACC;
      end
      ACC: begin
        ld_ans   = 1'b1;
        sub      = ALT_SIGN & ~k[0];
        state_nx = (k == K_LAST) ? DONE : MUL_X;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.terms_used = terms_used;
  assign bus.s1_rom     = s1_rom;
  assign bus.s1_x       = ~s1_rom;
  assign bus.s2_x       = s2_x;
  assign bus.s2_tmp     = ~s2_x;
  assign bus.s4_in      = s4_in;
  assign bus.s4_mult    = ~s4_in;
  assign bus.s3         = s3;
  assign bus.ld_tmp     = ld_tmp;
  assign bus.init_tmp   = init_tmp;
  assign bus.ld_ans     = ld_ans;
  assign bus.init_ans   = init_ans;
  assign bus.ld_x       = ld_x;
  assign bus.ld_y       = ld_y;
  assign bus.sub        = sub;

endmodule
